// File: rtl/gost89_ofb_stream_ctrl_pkg.sv
// Shared types and constants for the GOST 28147-89 OFB byte-stream front end.
package gost89_stream_pkg;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_LOAD,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_DRAIN
  } state_e;

  localparam int BYTE_W           = 8;
  localparam int BLOCK_W          = 64;
  localparam int BLOCK_BYTES      = 8;
  localparam int WDOG_LIMIT       = 63;
  localparam int CORE_BUSY_CYCLES = 33;

  // Byte idx 0 lands in bits [63:56]; the target lane is assumed to be zero.
  function automatic logic [BLOCK_W-1:0] pack_byte(input logic [BLOCK_W-1:0] blk,
                                                   input logic [2:0]         idx,
                                                   input logic [BYTE_W-1:0]  b);
    logic [5:0] sh;
    sh = {3'd7 - idx, 3'b000};
    return blk | ({{(BLOCK_W-BYTE_W){1'b0}}, b} << sh);
  endfunction

endpackage

// File: rtl/gost89_ofb_stream_ctrl_if.sv
// Byte-stream ports of the OFB front end: plaintext in (with IV), ciphertext out.
interface gost89_ofb_stream_ctrl_if;
  import gost89_stream_pkg::*;

  logic               s_valid;
  logic               s_ready;
  logic [BYTE_W-1:0]  s_data;
  logic               s_first;
  logic               s_last;
  logic [BLOCK_W-1:0] iv;
  logic               m_valid;
  logic               m_ready;
  logic [BYTE_W-1:0]  m_data;
  logic               m_last;

  modport master (
    output s_valid, s_data, s_first, s_last, iv, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, s_first, s_last, iv, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/gost89_block_serializer.sv
// Captures one 64-bit core result and emits its first N bytes MSB-first on a valid/ready port.
module gost89_block_serializer
  import gost89_stream_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               capture_i,
  input  logic [BLOCK_W-1:0] cap_data_i,
  input  logic [3:0]         cap_count_i,
  input  logic               cap_last_i,
  input  logic               m_ready_i,
  output logic               m_valid_o,
  output logic [BYTE_W-1:0]  m_data_o,
  output logic               m_last_o,
  output logic               done_o
);

  logic [BLOCK_W-1:0] shift_q;
  logic [3:0]         left_q;
  logic               last_q;
  logic               final_byte;

  assign final_byte = (left_q == 4'd1);
  assign m_valid_o  = (left_q != 4'd0);
  assign m_data_o   = shift_q[BLOCK_W-1 -: BYTE_W];
  assign m_last_o   = last_q & final_byte;
  assign done_o     = m_valid_o & m_ready_i & final_byte;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift_q <= '0;
      left_q  <= '0;
      last_q  <= 1'b0;
    end else if (capture_i) begin
      shift_q <= cap_data_i;
      left_q  <= cap_count_i;
      last_q  <= cap_last_i;
    end else if (m_valid_o && m_ready_i) begin
      shift_q <= shift_q << BYTE_W;
      left_q  <= left_q - 4'd1;
    end
  end

endmodule

// File: rtl/gost89_ofb_stream_ctrl.sv
// Packs an 8-bit stream into 64-bit blocks, sequences the GOST OFB core per block and
// serialises the result. Optional busy watchdog enabled by GOST_OFB_WATCHDOG_EN.
module gost89_ofb_stream_ctrl
  import gost89_stream_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  gost89_ofb_stream_ctrl_if.slave  strm,
  output logic                     core_reset,
  output logic                     core_load_data,
  output logic                     core_load_IV,
  output logic [BLOCK_W-1:0]       core_IV,
  output logic [BLOCK_W-1:0]       core_in,
  input  logic [BLOCK_W-1:0]       core_out,
  input  logic                     core_busy,
  output logic                     err
);

  state_e             state_q, state_d;
  logic [3:0]         count_q;
  logic [BLOCK_W-1:0] pack_q;
  logic [BLOCK_W-1:0] iv_q;
  logic               iv_pend_q;
  logic               blk_last_q;
  logic               core_reset_q;
  logic               s_ready;
  logic               accept;
  logic               capture;
  logic               ser_done;
  logic               wdog_hit;

  assign core_reset = core_reset_q | ~reset_n;
  assign accept     = strm.s_valid & s_ready;
  assign capture    = (state_q == ST_WAIT_LO) & ~core_busy;
  assign strm.s_ready = s_ready;
  assign core_in    = pack_q;
  assign core_IV    = iv_q;

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= ST_FILL;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL:    if (accept && (count_q == 4'(BLOCK_BYTES - 1) || accept && strm.s_last))
                    state_d = ST_LOAD;
      ST_LOAD:    state_d = ST_WAIT_HI;
      ST_WAIT_HI: if (core_busy) state_d = ST_WAIT_LO;
      ST_WAIT_LO: if (!core_busy) state_d = ST_DRAIN;
      ST_DRAIN:   if (ser_done) state_d = ST_FILL;
      default:    state_d = ST_FILL;
    endcase
    if (wdog_hit) state_d = ST_FILL;
  end

  // Input is held off while the core is being reset so no byte precedes a clean core.
  always_comb begin
    s_ready        = 1'b0;
    core_load_data = 1'b0;
    core_load_IV   = 1'b0;
    case (state_q)
      ST_FILL: s_ready = ~core_reset;
      ST_LOAD: begin
        core_load_data = reset_n;
        core_load_IV   = reset_n & iv_pend_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q      <= '0;
      pack_q       <= '0;
      iv_q         <= '0;
      iv_pend_q    <= 1'b0;
      blk_last_q   <= 1'b0;
      core_reset_q <= 1'b1;
    end else begin
      core_reset_q <= wdog_hit;
      if (accept) begin
        count_q <= count_q + 4'd1;
        pack_q  <= pack_byte(pack_q, count_q[2:0], strm.s_data);
        if (strm.s_last) blk_last_q <= 1'b1;
        if (strm.s_first && count_q == 4'd0) begin
          iv_q      <= strm.iv;
          iv_pend_q <= 1'b1;
        end
      end
      if (state_q == ST_LOAD) iv_pend_q <= 1'b0;
      if (ser_done || wdog_hit) begin
        count_q    <= '0;
        pack_q     <= '0;
        blk_last_q <= 1'b0;
      end
      // After an aborted block the core has been reset, so the next block must reload IV.
      if (wdog_hit) iv_pend_q <= 1'b1;
    end
  end

`ifdef GOST_OFB_WATCHDOG_EN
  logic [5:0] wdog_q;
  logic       err_q;
  logic       waiting;

  assign waiting  = (state_q == ST_WAIT_HI) || (state_q == ST_WAIT_LO);
  assign wdog_hit = waiting && (wdog_q == 6'(WDOG_LIMIT));
  assign err      = err_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= (waiting && !wdog_hit) ? wdog_q + 6'd1 : 6'd0;
      if (wdog_hit) err_q <= 1'b1;
    end
  end
`else
  assign wdog_hit = 1'b0;
  assign err      = 1'b0;
`endif

  gost89_block_serializer u_ser (
    .clk         (clk),
    .reset_n     (reset_n),
    .capture_i   (capture),
    .cap_data_i  (core_out),
    .cap_count_i (count_q),
    .cap_last_i  (blk_last_q),
    .m_ready_i   (strm.m_ready),
    .m_valid_o   (strm.m_valid),
    .m_data_o    (strm.m_data),
    .m_last_o    (strm.m_last),
    .done_o      (ser_done)
  );

endmodule

// File: doc/gost89_ofb_stream_ctrl.md
# gost89_ofb_stream_ctrl

Byte-stream front end for the GOST 28147-89 OFB encryptor core. It packs an 8-bit valid/ready input stream into 64-bit blocks and sequences the core through one 32-round block per load pulse. It captures the 64-bit ciphertext and serialises it back onto an 8-bit valid/ready output stream, honouring message boundaries, IV reload and truncated final blocks. It sits directly upstream and downstream of the encryptor core; key and S-box are tied at top level and do not pass through this block.

## Interface
Parameters:
- none. Constants live in the package.

Ports:
- clk  in  1  single clock for block and core
- reset_n  in  1  synchronous, active-low reset
- s_valid  in  1  input byte valid
- s_ready  out  1  input byte accepted when s_valid & s_ready
- s_data  in  8  plaintext byte
- s_first  in  1  byte is first of a message; IV is sampled with it
- s_last  in  1  byte is last of a message
- iv  in  64  message IV, sampled on the accepted s_first byte
- m_valid  out  1  output byte valid
- m_ready  in  1  downstream accepts output byte
- m_data  out  8  ciphertext byte
- m_last  out  1  final byte of the message
- core_reset  out  1  active-high reset to the core
- core_load_data  out  1  one-cycle block start pulse
- core_load_IV  out  1  qualifies core_load_data: load IV instead of feedback
- core_IV  out  64  IV to the core
- core_in  out  64  packed plaintext block, held stable until capture
- core_out  in  64  core result: keystream XOR core_in
- core_busy  in  1  core running
- err  out  1  sticky watchdog error

## Operation
- Packing: the first byte of a block goes to bits [63:56], and the eighth byte goes to bits [7:0]. A 4-bit count tracks bytes held (0..8). Unfilled bytes of a short block are zero.
- FSM states: FILL, LOAD, WAIT_HI, WAIT_LO, DRAIN.
- FILL:
  - s_ready=1.
  - Go to LOAD when the 8th byte is accepted, or when a byte with s_last is accepted (partial block, count 1..8).
- s_first handling:
  - An accepted s_first with count==0 latches iv into core_IV and sets iv_pend.
  - s_first with count≠0 is ignored.
- LOAD:
  - core_load_data=1 for exactly one cycle.
  - core_load_IV=iv_pend, then iv_pend clears.
  - Go to WAIT_HI.
- WAIT_HI: wait for core_busy=1, then go to WAIT_LO.
- WAIT_LO: on core_busy=0, register core_out and the byte count, then go to DRAIN.
- DRAIN:
  - Emit the captured bytes MSB-first, count bytes only; truncated bytes are never output.
  - m_last=1 on the final byte if the block carried s_last.
  - After the final handshake, clear count and go to FILL.
- Backpressure: m_ready=0 holds m_data/m_last stable. s_ready=0 in every state except FILL.
- A message whose first block lacks s_first continues OFB feedback from the previous block.
- Reset:
  - State→FILL, count=0, iv_pend=0, err=0.
  - s_ready=0, m_valid=0, m_last=0, core_load_data=0, core_load_IV=0, core_IV=0, core_in=0.
  - core_reset=1 while reset_n=0 and for one cycle after; otherwise 0.
- Reset mid-block discards all held and captured data.

## Timing
- 8th byte accepted in cycle n → LOAD in n+1 → core_busy=1 at n+2.
- The core holds busy for 33 cycles, so busy=0 at n+35 → capture at n+35 → m_valid=1 at n+36.
- An 8-byte block occupies 8 + 36 + 8 cycles minimum; there is no overlap between blocks.
- The block uses only the busy handshake and never a hard-coded 33-cycle count.
- s_ready first rises the cycle after core_reset deasserts.

## Configuration
- GOST_OFB_WATCHDOG_EN defined:
  - A 6-bit counter runs in WAIT_HI/WAIT_LO.
  - Reaching 63 sets err (sticky until reset), pulses core_reset for one cycle, discards the block and returns to FILL with iv_pend=1.
- Undefined: the block waits indefinitely, err is tied 0 and there is no counter.

## Structure
- Package gost89_stream_pkg holds:
  - the state enum
  - BLOCK_BYTES=8
  - WDOG_LIMIT=63
  - CORE_BUSY_CYCLES=33, used by the bench only
- One sub-module, gost89_block_serializer: the 64-bit capture register plus the byte-count-limited valid/ready output shifter for DRAIN.

## Test plan
- Reset with reset_n=0 for 3 cycles → core_reset high through the cycle after release; all other outputs 0; s_ready=1 one cycle later.
- 8 bytes 0x00..0x07 with s_first, iv=0x0123456789ABCDEF, against the core model → core_load_IV=1 with core_in=0x0001020304050607; m_valid 36 cycles after the 8th byte; output bytes equal the model ciphertext.
- 3-byte message 0xAA,0xBB,0xCC with s_last → core_in=0xAABBCC0000000000; exactly 3 output bytes, m_last on the third.
- Second 8-byte block without s_first → core_load_IV=0; output matches model OFB feedback.
- m_ready held low for 10 cycles mid-DRAIN → m_data stable, no byte lost or duplicated; s_ready=0 throughout.
- reset_n pulsed low while in WAIT_LO → no m_valid; the next message restarts cleanly. With GOST_OFB_WATCHDOG_EN, core_busy stuck at 1 → err=1 after 63 cycles and the FSM returns to FILL.
